switch_debounce_5ch: RTL
========================

// Module: switch_debounce_5ch
// PURPOSE
//  Conditions five raw board switch inputs before they drive the 5-input logic
//  gate stage (sw_db[4:0] maps to gate inputs {a,b,c,d,e}).
//  Each channel is synchronised, then debounced by a per-channel stability counter.
//  One-cycle rise/fall strobes are generated per channel.
//  Rejected bounces are counted for lab observation.
// PARAMETERS
//  WIDTH            5      number of switch channels
//  DEBOUNCE_CYCLES  50000  consecutive mismatch cycles needed to accept a new level (>=1; 1 ms @ 50 MHz)
//  CNT_W            16     stability counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES-1
// PORTS
//  clk        in   1      system clock, all logic on rising edge
//  rst        in   1      synchronous, active-high reset
//  sw_in      in   WIDTH  raw asynchronous switch levels; bit 4 = a ... bit 0 = e
//  sw_db      out  WIDTH  debounced levels, registered; feeds gate inputs
//  sw_rise    out  WIDTH  1-cycle strobe, asserted in the same cycle sw_db[i] goes 0->1
//  sw_fall    out  WIDTH  1-cycle strobe, asserted in the same cycle sw_db[i] goes 1->0
//  settled    out  1      1 when every channel's stability counter is 0 (no pending change)
//  glitch_cnt out  8      saturating count of rejected bounces, all channels combined
// BEHAVIOUR
//  Reset (rst=1 at a clk edge):
//   - sync1, sync2, sw_db, sw_rise, sw_fall, all counters and glitch_cnt clear to 0.
//   - settled=1.
//   - Reset takes priority over all other activity.
//   - A count in progress is discarded; a new level needs the full DEBOUNCE_CYCLES again.
//  Synchroniser: per channel, sync1 <= sw_in[i]; sync2 <= sync1. sync2 is the only level used below.
//  Per-channel counter cnt[i], evaluated each edge:
//   - sync2==sw_db[i], cnt==0: hold, no event.
//   - sync2==sw_db[i], cnt!=0: cnt<=0. This is a rejected bounce; raise glitch flag for channel i.
//   - sync2!=sw_db[i], cnt<DEBOUNCE_CYCLES-1: cnt<=cnt+1.
//   - sync2!=sw_db[i], cnt==DEBOUNCE_CYCLES-1:
//     - sw_db[i]<=sync2, cnt<=0.
//     - Pulse sw_rise[i] or sw_fall[i] per the new level.
//  Latency: a clean level change first sampled at edge 1 appears on sw_db at edge DEBOUNCE_CYCLES+2.
//  Strobes are exactly one cycle wide and cannot repeat on consecutive cycles for the same channel.
//  Channels are fully independent; simultaneous changes on several channels each complete on
//   their own schedule, and several strobes may be high in one cycle.
//  glitch_cnt:
//   - Adds the number of channels with a glitch flag this edge (0..WIDTH).
//   - Saturates at 255, never wraps.
//   - Cleared only by rst.
//  settled: combinational NOR of all (cnt!=0).
//  A mismatch lasting exactly DEBOUNCE_CYCLES cycles is accepted; one lasting DEBOUNCE_CYCLES-1 cycles is rejected.
// TESTING  (bench uses DEBOUNCE_CYCLES=4, WIDTH=5)
//  1. rst=1 for 3 edges with sw_in=5'b11111 -> sw_db=0, sw_rise=sw_fall=0, glitch_cnt=0, settled=1.
//  2. Step sw_in[4] 0->1 held -> sw_db[4]=1 at edge 6 after first sample; sw_rise[4]=1 that cycle only;
//     settled=0 during edges 3..5.
//  3. sw_in[0] high for 3 cycles, then low -> sw_db[0] stays 0, no strobe, glitch_cnt=1.
//     Same test with 4 cycles -> sw_db[0] rises, then falls 6 edges after the drop with sw_fall[0].
//  4. Sweep sw_in through 0..31, each held 10 cycles -> sw_db equals each pattern 6 edges after it
//     is applied, stays until the next change, and tracks the gate's full truth table.
//  5. Start a change on sw_in[2]; assert rst at count 2 and hold sw_in.
//     -> sw_db[2]=0 after reset; it sets only DEBOUNCE_CYCLES+2 edges after rst drops.
//  6. Drive 300 rejected 2-cycle pulses on sw_in[1] -> glitch_cnt reaches 255 and holds; sw_db[1] stays 0.

Source files
------------

// File: rtl/switch_debounce_5ch.sv
// Five-channel switch conditioner: 2-flop synchroniser, per-channel
// stability-counter debounce, edge strobes and a saturating bounce counter.
module switch_debounce_5ch #(
    parameter int WIDTH           = 5,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             settled,
    output logic [7:0]       glitch_cnt
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] db_q;
    logic [WIDTH-1:0] db_d;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] fall_d;
    logic [WIDTH-1:0] glitch;
    logic [WIDTH-1:0] busy;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [7:0]       gcnt_q;
    logic [7:0]       gcnt_d;
    logic [8:0]       gsum;

    always_comb begin
        db_d   = db_q;
        rise_d = '0;
        fall_d = '0;
        glitch = '0;
        busy   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            busy[i]  = (cnt_q[i] != '0);
            if (sync2_q[i] == db_q[i]) begin
                // Level returned before the count completed: a bounce.
                if (busy[i]) begin
                    cnt_d[i]  = '0;
                    glitch[i] = 1'b1;
                end
            end else if (cnt_q[i] == LAST) begin
                db_d[i]   = sync2_q[i];
                cnt_d[i]  = '0;
                rise_d[i] = sync2_q[i];
                fall_d[i] = ~sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        gsum = {1'b0, gcnt_q};
        for (int i = 0; i < WIDTH; i++) begin
            gsum = gsum + 9'(glitch[i]);
        end
        gcnt_d = gsum[8] ? 8'hFF : gsum[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            gcnt_q  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= sw_in;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            gcnt_q  <= gcnt_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw_db      = db_q;
    assign sw_rise    = rise_q;
    assign sw_fall    = fall_q;
    assign glitch_cnt = gcnt_q;
    assign settled    = ~|busy;

endmodule
